// File: rtl/btb_pkg.sv
// btb_pkg: default geometry and entry layout shared by the BTB top and its LRU helper.
// Entry widths follow these defaults; resize by editing them here.
package btb_pkg;

  localparam int NUM_SETS = 16;
  localparam int NUM_WAYS = 2;
  localparam int XLEN     = 32;
  localparam int IDX_W    = $clog2(NUM_SETS);
  localparam int TAG_W    = XLEN - IDX_W - 2;
  localparam int AGE_W    = $clog2(NUM_WAYS);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
  } btb_entry_t;

endpackage

// File: rtl/btb_lru.sv
// btb_lru: true-LRU age update for one set; applies read touches in lane order, then the write touch.
// Purely combinational (0 cycles); no backpressure, every touch is accepted.
module btb_lru #(
  parameter  int NUM_WAYS = btb_pkg::NUM_WAYS,
  localparam int AGE_W    = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0][AGE_W-1:0] ages,
  input  logic [1:0]                     rd_touch_vld,
  input  logic [1:0][AGE_W-1:0]          rd_touch_way,
  input  logic                           wr_touch_vld,
  input  logic [AGE_W-1:0]               wr_touch_way,
  output logic [NUM_WAYS-1:0][AGE_W-1:0] next_ages,
  output logic [AGE_W-1:0]               victim
);

  typedef logic [NUM_WAYS-1:0][AGE_W-1:0] ages_t;

  ages_t ages_mid;

  // Touched way becomes youngest; only ways younger than its old age grow older,
  // so a repeated touch of the same way is a no-op and ages stay a permutation.
  function automatic ages_t touch(input ages_t a, input logic [AGE_W-1:0] t);
    ages_t r;
    r = a;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (AGE_W'(w) == t) r[w] = '0;
      else if (a[w] < a[t]) r[w] = a[w] + 1'b1;
    end
    return r;
  endfunction

  always_comb begin
    ages_mid = ages;
    for (int l = 0; l < 2; l++) begin
      if (rd_touch_vld[l]) ages_mid = touch(ages_mid, rd_touch_way[l]);
    end
  end

  // Victim is chosen after this cycle's read touches, before the write itself.
  always_comb begin
    victim = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (ages_mid[w] == AGE_W'(NUM_WAYS - 1)) victim = AGE_W'(w);
    end
  end

  always_comb begin
    next_ages = ages_mid;
    if (wr_touch_vld) next_ages = touch(ages_mid, wr_touch_way);
  end

endmodule

// File: rtl/btb_assoc.sv
// btb_assoc: set-associative BTB with two lookup lanes, one install port, flush and true-LRU replacement.
// Lookup result registered 1 cycle after rd_en; no backpressure, reads and writes accepted every cycle.
module btb_assoc #(
  parameter  int NUM_SETS = btb_pkg::NUM_SETS,
  parameter  int NUM_WAYS = btb_pkg::NUM_WAYS,
  parameter  int XLEN     = btb_pkg::XLEN,
  localparam int IDX_W    = $clog2(NUM_SETS),
  localparam int TAG_W    = XLEN - IDX_W - 2,
  localparam int AGE_W    = $clog2(NUM_WAYS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           rd_en,
  input  logic [1:0][XLEN-1:0] rd_pc,
  input  logic                 wr_en,
  input  logic [XLEN-1:0]      wr_pc,
  input  logic [XLEN-1:0]      wr_target,
  input  logic                 flush,
  output logic [1:0]           rd_hit,
  output logic [1:0][XLEN-1:0] rd_target
);

  import btb_pkg::*;

  typedef logic [NUM_WAYS-1:0][AGE_W-1:0] ages_t;

  btb_entry_t        mem     [NUM_SETS][NUM_WAYS];
  ages_t             age     [NUM_SETS];
  ages_t             age_nxt [NUM_SETS];
  logic [AGE_W-1:0]  victim  [NUM_SETS];

  logic [1:0][IDX_W-1:0] rd_idx;
  logic [1:0][TAG_W-1:0] rd_tag;
  logic [1:0]            lk_hit;
  logic [1:0][AGE_W-1:0] lk_way;
  logic [1:0][XLEN-1:0]  lk_tgt;

  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             wr_hit, wr_inv;
  logic [AGE_W-1:0] wr_hit_way, wr_inv_way, wr_way;

  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{rd_pc[0][1:0], rd_pc[1][1:0], wr_pc[1:0]};

  // Lookups see pre-write contents, giving read-before-write on same-cycle collisions.
  always_comb begin
    for (int l = 0; l < 2; l++) begin
      rd_idx[l] = rd_pc[l][IDX_W+1:2];
      rd_tag[l] = rd_pc[l][XLEN-1:IDX_W+2];
      lk_hit[l] = 1'b0;
      lk_way[l] = '0;
      lk_tgt[l] = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (mem[rd_idx[l]][w].valid && mem[rd_idx[l]][w].tag == rd_tag[l]) begin
          lk_hit[l] = 1'b1;
          lk_way[l] = AGE_W'(w);
          lk_tgt[l] = mem[rd_idx[l]][w].target;
        end
      end
    end
  end

  always_comb begin
    wr_idx     = wr_pc[IDX_W+1:2];
    wr_tag     = wr_pc[XLEN-1:IDX_W+2];
    wr_hit     = 1'b0;
    wr_hit_way = '0;
    wr_inv     = 1'b0;
    wr_inv_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (mem[wr_idx][w].valid && mem[wr_idx][w].tag == wr_tag) begin
        wr_hit     = 1'b1;
        wr_hit_way = AGE_W'(w);
      end
      if (!mem[wr_idx][w].valid) begin
        wr_inv     = 1'b1;
        wr_inv_way = AGE_W'(w);
      end
    end
    wr_way = wr_hit ? wr_hit_way : (wr_inv ? wr_inv_way : victim[wr_idx]);
  end

  for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
    logic [1:0] rd_touch;
    logic       wr_touch;
    assign rd_touch[0] = rd_en[0] & lk_hit[0] & (rd_idx[0] == IDX_W'(s));
    assign rd_touch[1] = rd_en[1] & lk_hit[1] & (rd_idx[1] == IDX_W'(s));
    assign wr_touch    = wr_en & (wr_idx == IDX_W'(s));

    btb_lru #(.NUM_WAYS(NUM_WAYS)) u_lru (
      .ages         (age[s]),
      .rd_touch_vld (rd_touch),
      .rd_touch_way (lk_way),
      .wr_touch_vld (wr_touch),
      .wr_touch_way (wr_way),
      .next_ages    (age_nxt[s]),
      .victim       (victim[s])
    );
  end

  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          mem[s][w].valid <= 1'b0;
          age[s][w]       <= AGE_W'(w);
        end
      end
    end else begin
      for (int s = 0; s < NUM_SETS; s++) age[s] <= age_nxt[s];
      if (wr_en) mem[wr_idx][wr_way] <= '{valid: 1'b1, tag: wr_tag, target: wr_target};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_hit    <= '0;
      rd_target <= '0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        rd_hit[l]    <= rd_en[l] & lk_hit[l] & ~flush;
        rd_target[l] <= (rd_en[l] & lk_hit[l] & ~flush) ? lk_tgt[l] : '0;
      end
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// tb_btb_assoc: directed scenarios plus randomized traffic against a recency-list BTB model.
module tb_btb_assoc;

  localparam int NS = 16;
  localparam int NW = 2;
  localparam logic [31:0] PC_A = 32'h0000_102C;
  localparam logic [31:0] PC_B = 32'h0000_202C;
  localparam logic [31:0] PC_C = 32'h0000_302C;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [1:0]       rd_en = '0;
  logic [1:0][31:0] rd_pc = '0;
  logic             wr_en = 1'b0;
  logic [31:0]      wr_pc = '0;
  logic [31:0]      wr_target = '0;
  logic             flush = 1'b0;
  logic [1:0]       rd_hit;
  logic [1:0][31:0] rd_target;

  btb_assoc #(.NUM_SETS(NS), .NUM_WAYS(NW), .XLEN(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .rd_en     (rd_en),
    .rd_pc     (rd_pc),
    .wr_en     (wr_en),
    .wr_pc     (wr_pc),
    .wr_target (wr_target),
    .flush     (flush),
    .rd_hit    (rd_hit),
    .rd_target (rd_target)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  // Model: per set, contents keyed by pc[31:2] and a recency list (index 0 = most recent).
  bit        m_vld [NS][NW];
  bit [29:0] m_key [NS][NW];
  bit [31:0] m_tgt [NS][NW];
  int        m_rec [NS][NW];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int set_of(input logic [31:0] pc);
    return int'(pc[5:2]);
  endfunction

  function automatic int find(input logic [31:0] pc);
    int s = set_of(pc);
    for (int w = 0; w < NW; w++)
      if (m_vld[s][w] && m_key[s][w] == pc[31:2]) return w;
    return -1;
  endfunction

  function automatic void mdl_clear();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) begin
        m_vld[s][w] = 1'b0;
        m_rec[s][w] = w;
      end
  endfunction

  function automatic void mdl_touch(input int s, input int w);
    int p = 0;
    for (int i = 0; i < NW; i++) if (m_rec[s][i] == w) p = i;
    for (int i = p; i > 0; i--) m_rec[s][i] = m_rec[s][i-1];
    m_rec[s][0] = w;
  endfunction

  function automatic logic [31:0] mkpc();
    logic [3:0] s = ($urandom_range(0, 1) != 0) ? 4'hB : 4'h3;
    int         t = $urandom_range(1, 4);
    return (32'(t) << 6) | (32'(s) << 2) | 32'($urandom_range(0, 3));
  endfunction

  // Drive one cycle at the falling edge, advance the model, compare after the rising edge.
  task automatic cyc(input logic rst, input logic [1:0] re, input logic [31:0] p0,
                     input logic [31:0] p1, input logic we, input logic [31:0] wp,
                     input logic [31:0] wt, input logic fl);
    logic [31:0] pcs [2];
    int          wy  [2];
    logic [1:0]  e_hit;
    logic [31:0] e_tgt [2];
    int          s, w;
    reset = rst; rd_en = re; rd_pc[0] = p0; rd_pc[1] = p1;
    wr_en = we; wr_pc = wp; wr_target = wt; flush = fl;
    pcs[0] = p0; pcs[1] = p1;
    for (int l = 0; l < 2; l++) begin
      wy[l]    = find(pcs[l]);
      e_hit[l] = rst && re[l] && !fl && (wy[l] >= 0);
      e_tgt[l] = e_hit[l] ? m_tgt[set_of(pcs[l])][wy[l]] : 32'h0;
    end
    if (!rst || fl) mdl_clear();
    else begin
      for (int l = 0; l < 2; l++)
        if (re[l] && wy[l] >= 0) mdl_touch(set_of(pcs[l]), wy[l]);
      if (we) begin
        s = set_of(wp);
        w = find(wp);
        if (w < 0) begin
          for (int i = NW - 1; i >= 0; i--) if (!m_vld[s][i]) w = i;
          if (w < 0) w = m_rec[s][NW-1];
        end
        m_vld[s][w] = 1'b1;
        m_key[s][w] = wp[31:2];
        m_tgt[s][w] = wt;
        mdl_touch(s, w);
      end
    end
    @(posedge clock);
    #1;
    chk("hit", 32'(rd_hit), 32'(e_hit));
    chk("tgt0", rd_target[0], e_tgt[0]);
    chk("tgt1", rd_target[1], e_tgt[1]);
    @(negedge clock);
  endtask

  initial begin
    mdl_clear();
    @(negedge clock);

    // Reset, then a cold lookup on both lanes.
    cyc(1'b0, 2'b11, PC_A, PC_B, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("rst_hit", 32'(rd_hit), 32'h0);
    cyc(1'b1, 2'b11, PC_A, PC_B, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("cold_hit", 32'(rd_hit), 32'h0);
    chk("cold_tgt", rd_target[0] | rd_target[1], 32'h0);

    // Install A and B into the same set, read both in one cycle.
    cyc(1'b1, 2'b00, 32'h0, 32'h0, 1'b1, PC_A, 32'h1111_0000, 1'b0);
    cyc(1'b1, 2'b00, 32'h0, 32'h0, 1'b1, PC_B, 32'h2222_0000, 1'b0);
    cyc(1'b1, 2'b11, PC_A, PC_B, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("ab_hit", 32'(rd_hit), 32'h3);
    chk("ab_tgt0", rd_target[0], 32'h1111_0000);
    chk("ab_tgt1", rd_target[1], 32'h2222_0000);

    // Touch A, then C must evict B.
    cyc(1'b1, 2'b01, PC_A, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    cyc(1'b1, 2'b00, 32'h0, 32'h0, 1'b1, PC_C, 32'h3333_0000, 1'b0);
    cyc(1'b1, 2'b11, PC_A, PC_C, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("lru_tgt_a", rd_target[0], 32'h1111_0000);
    chk("lru_tgt_c", rd_target[1], 32'h3333_0000);
    cyc(1'b1, 2'b01, PC_B, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("lru_b_miss", 32'(rd_hit), 32'h0);

    // Read-before-write on A, then the update is visible and C is still resident.
    cyc(1'b1, 2'b01, PC_A, 32'h0, 1'b1, PC_A, 32'h4444_0000, 1'b0);
    chk("rbw_old", rd_target[0], 32'h1111_0000);
    cyc(1'b1, 2'b11, PC_A, PC_C, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("rbw_new", rd_target[0], 32'h4444_0000);
    chk("rbw_c", rd_target[1], 32'h3333_0000);

    // Flush drops a same-cycle write of C.
    cyc(1'b1, 2'b11, PC_A, PC_C, 1'b1, PC_C, 32'h5555_0000, 1'b1);
    chk("fl_same", 32'(rd_hit), 32'h0);
    cyc(1'b1, 2'b11, PC_A, PC_B, 1'b0, 32'h0, 32'h0, 1'b0);
    cyc(1'b1, 2'b01, PC_C, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("fl_c", 32'(rd_hit), 32'h0);

    // Reset pulse between writes and reads.
    cyc(1'b1, 2'b00, 32'h0, 32'h0, 1'b1, PC_A, 32'h6666_0000, 1'b0);
    cyc(1'b1, 2'b00, 32'h0, 32'h0, 1'b1, PC_B, 32'h7777_0000, 1'b0);
    cyc(1'b0, 2'b11, PC_A, PC_B, 1'b1, PC_C, 32'h8888_0000, 1'b0);
    chk("mid_rst", 32'(rd_hit), 32'h0);
    cyc(1'b1, 2'b11, PC_A, PC_B, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("post_rst", 32'(rd_hit), 32'h0);
    cyc(1'b1, 2'b01, PC_C, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);

    // Random traffic over two sets with four competing tags each.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] p0, p1;
      p0 = mkpc();
      p1 = ($urandom_range(0, 5) == 0) ? p0 : mkpc();
      cyc(($urandom_range(0, 199) != 0), 2'($urandom), p0, p1,
          1'($urandom), mkpc(), $urandom, ($urandom_range(0, 49) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
